// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage.
//
// Takes the EX_MEM bundle from the execute stage and performs loads and stores.
// Word accesses below PERIPH_BASE go to an internal single-cycle data RAM.
// Accesses at or above PERIPH_BASE go to a req/ack peripheral bus and stall
// the pipeline until the bus acknowledges or the timeout expires.
// The registered MEM_WB bundle feeds write-back and forwarding.
//
// Ports:
//   clk        rising-edge clock
//   reset_b    asynchronous active-low reset
//   EX_MEM     [31:0] store data, [63:32] address, [68:64] write reg,
//              [69] MemRead, [70] MemWrite, [71] RegWrite, [73:72] MemToReg,
//              [105:74] PC+4, [137:106] LUData, [138] LUOp
//   mem_wait   stall request to IF/ID/EX (combinational)
//   per_req    registered peripheral request
//   per_we     peripheral write enable
//   per_addr   peripheral byte address
//   per_wdata  peripheral write data
//   per_ack    peripheral completion pulse
//   per_rdata  peripheral read data, valid with per_ack
//   bus_err    sticky flag, set on a peripheral timeout
//   MEM_WB     [31:0] write-back data, [36:32] write reg, [37] RegWrite
module mem_stage #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
  parameter int          TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [138:0] EX_MEM,
  output logic         mem_wait,
  output logic         per_req,
  output logic         per_we,
  output logic [31:0]  per_addr,
  output logic [31:0]  per_wdata,
  input  logic         per_ack,
  input  logic [31:0]  per_rdata,
  output logic         bus_err,
  output logic [37:0]  MEM_WB
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // EX_MEM fields
  logic [31:0] store_data;
  logic [31:0] addr;
  logic [4:0]  wr_reg;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic [31:0] pc4;
  logic [31:0] lu_data;
  logic        lu_op;

  assign store_data = EX_MEM[31:0];
  assign addr       = EX_MEM[63:32];
  assign wr_reg     = EX_MEM[68:64];
  assign mem_read   = EX_MEM[69];
  assign mem_write  = EX_MEM[70];
  assign reg_write  = EX_MEM[71];
  assign mem_to_reg = EX_MEM[73:72];
  assign pc4        = EX_MEM[105:74];
  assign lu_data    = EX_MEM[137:106];
  assign lu_op      = EX_MEM[138];

  logic acc;
  logic periph;

  assign acc    = mem_read | mem_write;
  assign periph = acc & (addr >= PERIPH_BASE);

  // Bus signals follow EX_MEM directly; upstream holds EX_MEM while stalled.
  assign per_we    = mem_write;
  assign per_addr  = addr;
  assign per_wdata = store_data;

  // Data RAM: combinational read, index wraps modulo DEPTH, byte offset ignored.
  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_rdata;

  assign ram_idx   = addr[AW+1:2];
  assign ram_rdata = ram[ram_idx];

  // Contents are deliberately not reset. A simultaneous read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_write && !periph) begin
      ram[ram_idx] <= store_data;
    end
  end

  logic [31:0] wb_data;

  always_comb begin
    wb_data = pc4;
    case (mem_to_reg)
      2'b00:   wb_data = lu_op ? lu_data : addr;
      2'b01:   wb_data = ram_rdata;
      default: wb_data = pc4;
    endcase
  end

  // The stall is forced low while reset is held, so an abandoned access
  // releases the pipeline immediately.
  always_comb begin
    mem_wait = 1'b0;
    if (reset_b) begin
      case (state)
        IDLE:    mem_wait = periph;
        WAIT:    mem_wait = !per_ack && (cnt != TMAX);
        default: mem_wait = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= IDLE;
      cnt     <= '0;
      per_req <= 1'b0;
      bus_err <= 1'b0;
      MEM_WB  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (periph) begin
            MEM_WB  <= '0;
            per_req <= 1'b1;
            cnt     <= '0;
            state   <= WAIT;
          end else begin
            MEM_WB <= {reg_write, wr_reg, wb_data};
          end
        end
        WAIT: begin
          if (per_ack) begin
            MEM_WB  <= {reg_write, wr_reg,
                        (mem_to_reg == 2'b01) ? per_rdata : wb_data};
            per_req <= 1'b0;
            state   <= IDLE;
          end else if (cnt == TMAX) begin
            // Aborted loads return a recognisable poison value.
            MEM_WB  <= {reg_write, wr_reg,
                        mem_read ? 32'hDEAD_BEEF : wb_data};
            bus_err <= 1'b1;
            per_req <= 1'b0;
            state   <= IDLE;
          end else begin
            MEM_WB <= '0;
            cnt    <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed self-checking bench for mem_stage.
// Inputs change on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge, combinational ones 1 time unit after driving.
module tb_mem_stage;

  logic         clk;
  logic         reset_b;
  logic [138:0] ex_mem;
  logic         mem_wait;
  logic         per_req;
  logic         per_we;
  logic [31:0]  per_addr;
  logic [31:0]  per_wdata;
  logic         per_ack;
  logic [31:0]  per_rdata;
  logic         bus_err;
  logic [37:0]  mem_wb;

  int checks;
  int failures;

  mem_stage #(
    .DEPTH(16),
    .PERIPH_BASE(32'h4000_0000),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .EX_MEM(ex_mem),
    .mem_wait(mem_wait),
    .per_req(per_req),
    .per_we(per_we),
    .per_addr(per_addr),
    .per_wdata(per_wdata),
    .per_ack(per_ack),
    .per_rdata(per_rdata),
    .bus_err(bus_err),
    .MEM_WB(mem_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Packs an EX_MEM bundle from its fields.
  function automatic logic [138:0] mk(
    input logic [31:0] store, input logic [31:0] addr, input logic [4:0] wr,
    input logic mr, input logic mw, input logic rw, input logic [1:0] m2r,
    input logic [31:0] pc4, input logic [31:0] lud, input logic luop);
    return {luop, lud, pc4, m2r, rw, mw, mr, wr, addr, store};
  endfunction

  task automatic applyStimulus(input logic [138:0] ex);
    @(negedge clk);
    ex_mem = ex;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wb(input logic rw, input logic [4:0] r,
                                     input logic [31:0] d);
    return {26'd0, rw, r, d};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset_b  = 1'b0;
    ex_mem   = '0;
    per_ack  = 1'b0;
    per_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_memwb", 64'(mem_wb), 64'd0);
    checkOutput("rst_perreq", 64'(per_req), 64'd0);
    checkOutput("rst_buserr", 64'(bus_err), 64'd0);
    checkOutput("rst_memwait", 64'(mem_wait), 64'd0);
    @(negedge clk);
    reset_b = 1'b1;

    // Store then load from RAM
    applyStimulus(mk(32'h1234_5678, 32'h10, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0));
    checkOutput("sw_wait", 64'(mem_wait), 64'd0);
    clockEdge();
    applyStimulus(mk(0, 32'h10, 5'd8, 1, 0, 1, 2'b01, 0, 0, 0));
    checkOutput("lw_wait", 64'(mem_wait), 64'd0);
    clockEdge();
    checkOutput("lw_data", 64'(mem_wb), wb(1, 8, 32'h1234_5678));

    // ALU, LUI, jal passthrough
    applyStimulus(mk(0, 32'h55, 5'd3, 0, 0, 1, 2'b00, 0, 0, 0));
    clockEdge();
    checkOutput("alu", 64'(mem_wb), wb(1, 3, 32'h55));
    applyStimulus(mk(0, 32'h77, 5'd4, 0, 0, 1, 2'b00, 0, 32'hABCD_0000, 1));
    clockEdge();
    checkOutput("lui", 64'(mem_wb), wb(1, 4, 32'hABCD_0000));
    applyStimulus(mk(0, 32'h99, 5'd31, 0, 0, 1, 2'b10, 32'h0040_0008, 0, 0));
    clockEdge();
    checkOutput("jal", 64'(mem_wb), wb(1, 31, 32'h0040_0008));
    applyStimulus(mk(0, 32'h99, 5'd0, 0, 0, 1, 2'b11, 32'h0040_0100, 0, 0));
    clockEdge();
    checkOutput("m2r11_r0", 64'(mem_wb), wb(1, 0, 32'h0040_0100));

    // Read and write in the same cycle: load sees the old word
    applyStimulus(mk(32'h1111_1111, 32'h20, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0));
    clockEdge();
    applyStimulus(mk(32'h2222_2222, 32'h20, 5'd5, 1, 1, 1, 2'b01, 0, 0, 0));
    clockEdge();
    checkOutput("rw_old", 64'(mem_wb), wb(1, 5, 32'h1111_1111));
    applyStimulus(mk(0, 32'h20, 5'd5, 1, 0, 1, 2'b01, 0, 0, 0));
    clockEdge();
    checkOutput("rw_new", 64'(mem_wb), wb(1, 5, 32'h2222_2222));

    // Last RAM word below the peripheral region
    applyStimulus(mk(32'hCAFE_F00D, 32'h3FFF_FFFC, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0));
    checkOutput("below_sw_wait", 64'(mem_wait), 64'd0);
    clockEdge();
    applyStimulus(mk(0, 32'h3FFF_FFFC, 5'd6, 1, 0, 1, 2'b01, 0, 0, 0));
    checkOutput("below_lw_wait", 64'(mem_wait), 64'd0);
    clockEdge();
    checkOutput("below_lw", 64'(mem_wb), wb(1, 6, 32'hCAFE_F00D));

    // Peripheral load: three empty WAIT cycles, ack in the fourth
    applyStimulus(mk(0, 32'h4000_0018, 5'd9, 1, 0, 1, 2'b01, 0, 0, 0));
    checkOutput("pl_idle_wait", 64'(mem_wait), 64'd1);
    checkOutput("pl_idle_req", 64'(per_req), 64'd0);
    checkOutput("pl_addr", 64'(per_addr), 64'h4000_0018);
    checkOutput("pl_we", 64'(per_we), 64'd0);
    clockEdge();
    checkOutput("pl_bubble0", 64'(mem_wb), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ex_mem);
      checkOutput("pl_wait", 64'(mem_wait), 64'd1);
      checkOutput("pl_req", 64'(per_req), 64'd1);
      clockEdge();
      checkOutput("pl_bubble", 64'(mem_wb), 64'd0);
    end
    @(negedge clk);
    per_ack = 1'b1;
    per_rdata = 32'h41;
    #1;
    checkOutput("pl_ack_wait", 64'(mem_wait), 64'd0);
    clockEdge();
    per_ack = 1'b0;
    checkOutput("pl_data", 64'(mem_wb), wb(1, 9, 32'h41));
    checkOutput("pl_req_done", 64'(per_req), 64'd0);

    // Peripheral store must not touch the aliased RAM word
    applyStimulus(mk(32'h0000_AAAA, 32'h4, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0));
    clockEdge();
    applyStimulus(mk(32'h0000_BBBB, 32'h4000_0004, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0));
    checkOutput("ps_we", 64'(per_we), 64'd1);
    checkOutput("ps_wdata", 64'(per_wdata), 64'h0000_BBBB);
    clockEdge();
    @(negedge clk);
    per_ack = 1'b1;
    #1;
    clockEdge();
    per_ack = 1'b0;
    checkOutput("ps_wb", 64'(mem_wb), wb(0, 0, 32'h4000_0004));
    applyStimulus(mk(0, 32'h4, 5'd7, 1, 0, 1, 2'b01, 0, 0, 0));
    clockEdge();
    checkOutput("ps_ram_kept", 64'(mem_wb), wb(1, 7, 32'h0000_AAAA));

    // Timeout with TIMEOUT=4 and no ack
    applyStimulus(mk(0, 32'h4000_0020, 5'd10, 1, 0, 1, 2'b01, 0, 0, 0));
    checkOutput("to_idle_wait", 64'(mem_wait), 64'd1);
    clockEdge();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ex_mem);
      checkOutput("to_wait", 64'(mem_wait), 64'd1);
      clockEdge();
      checkOutput("to_bubble", 64'(mem_wb), 64'd0);
      checkOutput("to_noerr", 64'(bus_err), 64'd0);
    end
    applyStimulus(ex_mem);
    checkOutput("to_last_wait", 64'(mem_wait), 64'd0);
    checkOutput("to_last_req", 64'(per_req), 64'd1);
    clockEdge();
    checkOutput("to_data", 64'(mem_wb), wb(1, 10, 32'hDEAD_BEEF));
    checkOutput("to_err", 64'(bus_err), 64'd1);
    checkOutput("to_req_off", 64'(per_req), 64'd0);
    applyStimulus(mk(0, 32'h55, 5'd3, 0, 0, 1, 2'b00, 0, 0, 0));
    clockEdge();
    checkOutput("to_err_sticky", 64'(bus_err), 64'd1);

    // Wrap and alignment: 4*DEPTH+2 aliases word 0
    applyStimulus(mk(32'h0BAD_F00D, 32'd66, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0));
    clockEdge();
    applyStimulus(mk(0, 32'd0, 5'd11, 1, 0, 1, 2'b01, 0, 0, 0));
    clockEdge();
    checkOutput("wrap", 64'(mem_wb), wb(1, 11, 32'h0BAD_F00D));

    // Reset in the middle of a peripheral access
    applyStimulus(mk(0, 32'h4000_0030, 5'd12, 1, 0, 1, 2'b01, 0, 0, 0));
    clockEdge();
    applyStimulus(ex_mem);
    clockEdge();
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    checkOutput("mr_req", 64'(per_req), 64'd0);
    checkOutput("mr_wait", 64'(mem_wait), 64'd0);
    checkOutput("mr_memwb", 64'(mem_wb), 64'd0);
    checkOutput("mr_err", 64'(bus_err), 64'd0);
    @(negedge clk);
    reset_b = 1'b1;
    ex_mem = mk(0, 32'h10, 5'd13, 1, 0, 1, 2'b01, 0, 0, 0);
    per_ack = 1'b1;
    per_rdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("mr_ack_ign_wait", 64'(mem_wait), 64'd0);
    clockEdge();
    per_ack = 1'b0;
    checkOutput("mr_ack_ign_req", 64'(per_req), 64'd0);
    checkOutput("mr_load", 64'(mem_wb), wb(1, 13, 32'h1234_5678));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
